// File: rtl/uart_tx_arb_if.sv
// rtl/uart_tx_arb_if.sv - requester and uart_tx byte handshake bundle for uart_tx_arb
interface uart_tx_arb_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_vld;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_rdy;
   logic [7:0]           tx_data;
   logic                 tx_vld;
   logic                 tx_rdy;
   logic [NUM_REQ-1:0]   grant;
   logic                 busy;
   logic                 timeout_err;

   modport slave (
      input  req_vld, req_data, req_last, tx_rdy,
      output req_rdy, tx_data, tx_vld, grant, busy, timeout_err
   );

   modport master (
      output req_vld, req_data, req_last, tx_rdy,
      input  req_rdy, tx_data, tx_vld, grant, busy, timeout_err
   );
endinterface

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - message-granular round-robin arbiter sharing one uart_tx
// Optional idle-grant watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst,
   uart_tx_arb_if.slave bus
);
   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE, OWN} state_e;

   state_e              state_q, state_d;
   logic [IDXW-1:0]     owner_q, owner_d;
   logic [IDXW-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic                timeout_q, timeout_d;
   logic [IDXW-1:0]     pick;
   logic                pick_vld;
   logic                own;
   logic                hs;
   logic                expire;

   assign own = (state_q == OWN);
   assign hs  = own && bus.req_vld[owner_q] && bus.tx_rdy;

   // Descending scan so the requester closest after ptr is written last and wins.
   always_comb begin
      int j;
      j        = 0;
      pick     = ptr_q;
      pick_vld = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j = (int'(ptr_q) + k) % NUM_REQ;
         if (bus.req_vld[j]) begin
            pick     = IDXW'(j);
            pick_vld = 1'b1;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNTW-1:0] cnt_q, cnt_d;

   // Only owner silence counts; a stalled uart_tx with a pending byte never does.
   always_comb begin
      cnt_d  = cnt_q;
      expire = 1'b0;
      if (!own || hs) begin
         cnt_d = '0;
      end else if (!bus.req_vld[owner_q]) begin
         cnt_d  = cnt_q + 1'b1;
         expire = (cnt_d == CNTW'(TIMEOUT_CYCLES));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign expire             = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d = OWN;
               owner_d = pick;
               grant_d = NUM_REQ'(1) << pick;
            end
         end
         OWN: begin
            if (hs && bus.req_last[owner_q]) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = owner_q;
            end else if (expire) begin
               state_d   = IDLE;
               grant_d   = '0;
               ptr_d     = owner_q;
               timeout_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= IDXW'(NUM_REQ - 1);
         grant_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.busy        = own;
   assign bus.tx_vld      = own && bus.req_vld[owner_q];
   assign bus.tx_data     = own ? bus.req_data[{owner_q, 3'b000} +: 8] : 8'h00;
   assign bus.req_rdy     = grant_q & {NUM_REQ{bus.tx_rdy}};
   assign bus.timeout_err = timeout_q;
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one `uart_tx` byte transmitter between `NUM_REQ` independent requesters. Arbitration is message-granular: a requester holds the transmitter from its first byte through the byte flagged `req_last`, so multi-byte messages are never interleaved on the serial line. It sits between the command/response sources and the single `uart_tx` instance, using the same valid/ready byte handshake as the rest of the UART datapath.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `TIMEOUT_CYCLES`, 1024, idle-grant watchdog limit in `clk` cycles (used only with `UART_ARB_TIMEOUT_EN`)
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `req_vld`  in  NUM_REQ  per-requester byte valid
- `req_data`  in  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i]
- `req_last`  in  NUM_REQ  byte is final byte of message
- `req_rdy`  out  NUM_REQ  byte accepted (only the granted bit can be 1)
- `tx_data`  out  8  byte to `uart_tx`
- `tx_vld`  out  1  byte valid to `uart_tx`
- `tx_rdy`  in  1  `uart_tx` can accept byte
- `grant`  out  NUM_REQ  one-hot current owner, all-zero when idle
- `busy`  out  1  a grant is held
- `timeout_err`  out  1  one-cycle pulse on watchdog revoke

## Operation
- States: IDLE, OWN.
- IDLE: `grant`=0, `tx_vld`=0, `req_rdy`=0. If any `req_vld` is set, choose the first set bit scanning upward (with wrap) from `ptr+1`, register it into `grant`, then go to OWN.
- OWN (owner g): combinational pass-through: `tx_vld`=`req_vld[g]`, `tx_data`=`req_data[g]`, `req_rdy[g]`=`tx_rdy`, all other `req_rdy`=0.
- A handshake (`req_vld[g]&tx_rdy`) with `req_last[g]`=1 ends the message: `ptr`<=g, `grant`<=0, go to IDLE.
- Handshake with `req_last[g]`=0 stays in OWN. Owner may deassert `req_vld` between bytes without losing grant.
- Non-owner `req_vld` is ignored during OWN; those requesters must hold `req_vld`/data stable until they get `req_rdy`.
- `ptr` resets to NUM_REQ-1, so requester 0 has priority after reset.
- `busy` = (state==OWN).
- Single-byte message (first byte has `req_last`=1) is legal: one OWN cycle minimum if `tx_rdy`=1.

## Timing
- Reset values: `grant`=0, `busy`=0, `tx_vld`=0, `tx_data`=0, `req_rdy`=0, `timeout_err`=0, `ptr`=NUM_REQ-1, state IDLE.
- Arbitration latency: `req_vld` sampled high in IDLE at edge n, so `grant`/`tx_vld` are high after edge n+1.
- Turnaround: last-byte handshake at edge n puts the block in IDLE for cycle n+1. The next grant is visible after edge n+2, so there is one idle cycle between messages.
- `tx_vld`, `tx_data` and `req_rdy` are combinational from the registered `grant`, so there are no extra pipeline stages.
- `rst` asserted mid-message: outputs clear immediately (asynchronous reset). A partially accepted message is abandoned, and the requester must restart it.
- Simultaneous requests in IDLE: the round-robin order from `ptr+1` decides the winner. With all requesters active, each gets exactly one message in turn.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter clears on grant and on every handshake.
  - It increments each OWN cycle with `req_vld[g]`=0.
  - On reaching `TIMEOUT_CYCLES`: `grant`<=0, `ptr`<=g, go to IDLE, and `timeout_err` pulses high for one cycle.
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits and saturation is not needed.
  - `tx_rdy`=0 stalls never count.
- Not defined: no counter, grant is held until `req_last`, and `timeout_err` is tied 0.

## Test plan
- After reset, req 0 and req 2 both assert with 2-byte messages (0x12,0x34 / 0xAA,0x55), `tx_rdy`=1 → `tx_data` sequence is 0x12,0x34,0xAA,0x55, `grant` is 0001 then 0100, with one idle cycle between.
- All 4 requesters continuously send 1-byte messages (value = index) → output order is 0x00,0x01,0x02,0x03,0x00… with no starvation.
- Req 1 sends 3 bytes while req 3 asserts mid-message, `tx_rdy` toggled every other cycle → req 1 bytes are contiguous and unbroken, and req 3 is granted only after req 1's `req_last` handshake.
- Assert `rst` during byte 2 of a 4-byte message → `grant`, `tx_vld` and `req_rdy` go 0 immediately, and after release requester 0 wins the first arbitration.
- With the macro, `TIMEOUT_CYCLES`=16: req 2 sends one non-last byte, then drops `req_vld` → after 16 cycles `timeout_err` pulses for one cycle, `grant`=0, and waiting req 3 is granted next.
- Without the macro, the same stimulus → grant is held indefinitely and `timeout_err` stays 0.
